// File: rtl/usb_rw_arbiter.sv
// usb_rw_arbiter
//   Shares one USB read/write transaction FSM between N_REQ host-side requesters.
//   Pending requests are granted round-robin, one transaction at a time. The granted
//   request's operands are latched, a one-cycle start pulse is sent to the FSM, and the
//   arbiter waits for fsm_done (or aborts after TIMEOUT_CYCLES wait cycles). The result is
//   returned to the requester as a one-cycle response.
//
// Ports
//   clk, rst_b           clock, synchronous active-low reset
//   req_read/req_write   per-requester level requests, held until req_ack
//   req_mempage          per-requester page, slice i = [16*i +: 16]
//   req_wdata            per-requester write data, slice i = [64*i +: 64]
//   req_ack              one-hot completion pulse
//   rsp_valid/id/data    response pulse, requester index, read data (0 for writes/timeouts)
//   rsp_timeout          completion was a timeout abort
//   busy                 arbiter is not idle
//   fsm_read/fsm_write   start pulses towards the transaction FSM
//   fsm_mempage/data_in  operands of the current transaction
//   fsm_abort            watchdog abort pulse
//   fsm_valueRead        read data from the FSM, valid with fsm_done
//   fsm_done             FSM transaction complete
module usb_rw_arbiter #(
  parameter int unsigned  N_REQ          = 4,
  parameter int unsigned  TIMEOUT_CYCLES = 1024,
  localparam int unsigned ID_W           = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [N_REQ-1:0]      req_read,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [N_REQ*16-1:0]   req_mempage,
  input  logic [N_REQ*64-1:0]   req_wdata,
  output logic [N_REQ-1:0]      req_ack,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_data,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  fsm_read,
  output logic                  fsm_write,
  output logic [15:0]           fsm_mempage,
  output logic [63:0]           fsm_data_in,
  output logic                  fsm_abort,
  input  logic [63:0]           fsm_valueRead,
  input  logic                  fsm_done
);

  localparam int unsigned    CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   id_q;
  logic              op_read_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       mempage_q;
  logic [63:0]       wdata_q;
  logic              fsm_read_q;
  logic              fsm_write_q;
  logic [N_REQ-1:0]  req_ack_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [63:0]       rsp_data_q;
  logic              rsp_timeout_q;

  logic [N_REQ-1:0]  pending;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic [31:0]       scan_idx;

  assign pending = req_read | req_write;

  // Round-robin pick: first pending index scanning ptr, ptr+1, ... modulo N_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!grant_valid && pending[scan_idx[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      id_q          <= '0;
      op_read_q     <= 1'b0;
      cnt_q         <= '0;
      mempage_q     <= '0;
      wdata_q       <= '0;
      fsm_read_q    <= 1'b0;
      fsm_write_q   <= 1'b0;
      req_ack_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // Start pulses and response fields are single-cycle by default.
      fsm_read_q    <= 1'b0;
      fsm_write_q   <= 1'b0;
      req_ack_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            id_q      <= grant_idx;
            // Read wins when both read and write are requested.
            op_read_q   <= req_read[grant_idx];
            fsm_read_q  <= req_read[grant_idx];
            fsm_write_q <= ~req_read[grant_idx];
            mempage_q   <= req_mempage[16*grant_idx +: 16];
            wdata_q     <= req_wdata[64*grant_idx +: 64];
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (fsm_done) begin
            rsp_valid_q     <= 1'b1;
            req_ack_q[id_q] <= 1'b1;
            rsp_id_q        <= id_q;
            rsp_data_q      <= op_read_q ? fsm_valueRead : 64'd0;
            state_q         <= StResp;
          end else if (cnt_q == CntLast) begin
            rsp_valid_q     <= 1'b1;
            req_ack_q[id_q] <= 1'b1;
            rsp_id_q        <= id_q;
            rsp_timeout_q   <= 1'b1;
            state_q         <= StResp;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StResp: begin
          ptr_q   <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Abort is flagged in the last wait cycle itself; a coincident done takes precedence and
  // a reset in that cycle suppresses it.
  assign fsm_abort   = rst_b && (state_q == StWait) && !fsm_done && (cnt_q == CntLast);

  assign busy        = (state_q != StIdle);
  assign fsm_read    = fsm_read_q;
  assign fsm_write   = fsm_write_q;
  assign fsm_mempage = mempage_q;
  assign fsm_data_in = wdata_q;
  assign req_ack     = req_ack_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_usb_rw_arbiter.sv
module tb_usb_rw_arbiter;
  localparam int unsigned NReq = 4;
  localparam int unsigned Tmo  = 16;

  logic              clk = 1'b0;
  logic              rst_b;
  logic [NReq-1:0]   req_read, req_write, req_ack;
  logic [NReq*16-1:0] req_mempage;
  logic [NReq*64-1:0] req_wdata;
  logic              rsp_valid, rsp_timeout, busy, fsm_read, fsm_write, fsm_abort, fsm_done;
  logic [1:0]        rsp_id;
  logic [63:0]       rsp_data, fsm_data_in, fsm_valueRead;
  logic [15:0]       fsm_mempage;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  usb_rw_arbiter #(.N_REQ(NReq), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk(clk), .rst_b(rst_b), .req_read(req_read), .req_write(req_write),
    .req_mempage(req_mempage), .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy), .fsm_read(fsm_read), .fsm_write(fsm_write), .fsm_mempage(fsm_mempage),
    .fsm_data_in(fsm_data_in), .fsm_abort(fsm_abort), .fsm_valueRead(fsm_valueRead),
    .fsm_done(fsm_done)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [15:0] page;
    logic [63:0] wdata;
    int          delay;     // cycles after the start pulse at which fsm_done is driven
    logic [63:0] value;
    int          exp_id;
    logic        exp_rd;
    logic [63:0] exp_data;
    logic        exp_to;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_read = '0; req_write = '0; req_mempage = '0; req_wdata = '0;
    fsm_done = 1'b0; fsm_valueRead = '0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctl"}, 64'({req_ack, rsp_valid, rsp_id, rsp_timeout, busy, fsm_read,
                              fsm_write, fsm_abort, fsm_mempage}), 64'd0);
    check({name, " rsp_data"}, rsp_data, 64'd0);
    check({name, " fsm_data_in"}, fsm_data_in, 64'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_b = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_b = 1'b1;
  endtask

  // Random operands on every slice, then the requester's own operands on its slice.
  task automatic set_operands(input int id, input logic [15:0] pg, input logic [63:0] wd);
    for (int i = 0; i < NReq; i++) begin
      req_mempage[16*i +: 16] = 16'($urandom);
      req_wdata[64*i +: 64]   = {$urandom, $urandom};
    end
    req_mempage[16*id +: 16] = pg;
    req_wdata[64*id +: 64]   = wd;
  endtask

  task automatic run_txn(input vec_t v);
    int exp_j, last_j;
    set_operands(v.exp_id, v.page, v.wdata);
    req_read  = v.rd;
    req_write = v.wr;
    step();
    check("start op", {fsm_read, fsm_write}, {v.exp_rd, ~v.exp_rd});
    check("start page", fsm_mempage, v.page);
    if (!v.exp_rd) check("start wdata", fsm_data_in, v.wdata);
    check("busy at issue", busy, 1'b1);
    // Later operand changes must not reach the FSM side.
    set_operands(v.exp_id, ~v.page, ~v.wdata);
    exp_j  = ((v.delay < Tmo) ? v.delay : Tmo) + 1;
    last_j = ((exp_j > v.delay) ? exp_j : v.delay) + 2;
    for (int j = 1; j <= last_j; j++) begin
      step();
      if (j == exp_j) begin
        check("ack onehot", req_ack, NReq'(1) << v.exp_id);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, v.exp_id);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_timeout", rsp_timeout, v.exp_to);
        check("page held", fsm_mempage, v.page);
        check("busy at resp", busy, 1'b1);
        req_read  = '0;
        req_write = '0;
      end else begin
        check("no ack", {req_ack, rsp_valid}, 5'd0);
        check("single start", {fsm_read, fsm_write}, 2'd0);
        check("busy", busy, j < exp_j);
      end
      fsm_done      = (j == v.delay);
      fsm_valueRead = fsm_done ? v.value : ~v.value;
      #1;
      check("abort", fsm_abort, (j == Tmo) && (v.delay > Tmo));
    end
    fsm_done = 1'b0;
  endtask

  // Randomized traffic against a transaction-level model: round-robin over the request
  // set seen before the start pulse, response exactly min(delay, Tmo)+1 cycles later.
  task automatic run_random(input int ncyc);
    logic [NReq-1:0] rd, wr, s_rd, s_wr;
    logic [15:0]     pg [NReq];
    logic [63:0]     wd [NReq];
    int              gap [NReq];
    int              ptr, dly, ack_c, done_at, abort_c, exp_id, cand;
    bit              outst, idle_prev, idle_now, exp_pulse, exp_rd, acked;
    logic [63:0]     val;
    rd = '0; wr = '0; s_rd = '0; s_wr = '0; ptr = 0; dly = 0; ack_c = -1; done_at = -1;
    abort_c = -1; exp_id = 0; outst = 0; idle_prev = 1; exp_rd = 0; val = '0;
    for (int i = 0; i < NReq; i++) begin
      gap[i] = 0; pg[i] = '0; wd[i] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      step();
      acked = 0;
      if (outst && c == ack_c) begin
        check("rnd ack", req_ack, NReq'(1) << exp_id);
        check("rnd rsp_valid", rsp_valid, 1'b1);
        check("rnd rsp_id", rsp_id, exp_id);
        check("rnd rsp_timeout", rsp_timeout, dly > Tmo);
        check("rnd rsp_data", rsp_data, (exp_rd && dly <= Tmo) ? val : 64'd0);
        ptr = (exp_id + 1) % NReq;
        outst = 0;
        acked = 1;
        rd[exp_id] = 1'b0;
        wr[exp_id] = 1'b0;
        gap[exp_id] = $urandom_range(5, 1);
      end else begin
        check("rnd idle rsp", {rsp_valid, req_ack}, 5'd0);
      end
      exp_pulse = idle_prev && (|(s_rd | s_wr));
      check("rnd start", fsm_read | fsm_write, exp_pulse);
      if (exp_pulse) begin
        exp_id = -1;
        for (int k = 0; k < NReq; k++) begin
          cand = (ptr + k) % NReq;
          if (exp_id < 0 && (s_rd[cand] | s_wr[cand])) exp_id = cand;
        end
        exp_rd = s_rd[exp_id];
        check("rnd op", {fsm_read, fsm_write}, {exp_rd, !exp_rd});
        check("rnd page", fsm_mempage, pg[exp_id]);
        if (!exp_rd) check("rnd wdata", fsm_data_in, wd[exp_id]);
        outst   = 1;
        dly     = ($urandom_range(9, 0) == 0) ? $urandom_range(18, 14) : $urandom_range(8, 1);
        ack_c   = c + ((dly < Tmo) ? dly : Tmo) + 1;
        done_at = c + dly;
        abort_c = (dly > Tmo) ? c + Tmo : -1;
        val     = {$urandom, $urandom};
      end
      idle_now = !outst && !acked;
      check("rnd busy", busy, !idle_now);
      idle_prev = idle_now;

      fsm_done      = (c == done_at);
      fsm_valueRead = fsm_done ? val : {$urandom, $urandom};
      for (int i = 0; i < NReq; i++) begin
        if (!(rd[i] | wr[i])) begin
          if (gap[i] > 0) gap[i]--;
          else if ($urandom_range(2, 0) == 0) begin
            case ($urandom_range(2, 0))
              0:       rd[i] = 1'b1;
              1:       wr[i] = 1'b1;
              default: begin rd[i] = 1'b1; wr[i] = 1'b1; end
            endcase
            pg[i] = 16'($urandom);
            wd[i] = {$urandom, $urandom};
          end
        end
        req_mempage[16*i +: 16] = pg[i];
        req_wdata[64*i +: 64]   = wd[i];
      end
      req_read = rd; req_write = wr;
      s_rd = rd; s_wr = wr;
      #1;
      check("rnd abort", fsm_abort, c == abort_c);
    end
    clear_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   got[$];
    int   exp_order[6];
    bit   inflight;
    int   overlaps, done_at, re_id, re_at;

    vecs[0] = '{rd: 4'b0001, wr: 4'b0000, page: 16'h1234, wdata: 64'h0, delay: 5,
                value: 64'hDEADBEEFCAFEF00D, exp_id: 0, exp_rd: 1'b1,
                exp_data: 64'hDEADBEEFCAFEF00D, exp_to: 1'b0};
    vecs[1] = '{rd: 4'b0000, wr: 4'b0100, page: 16'h00A5, wdata: 64'h0123456789ABCDEF,
                delay: 3, value: 64'h5555AAAA5555AAAA, exp_id: 2, exp_rd: 1'b0,
                exp_data: 64'h0, exp_to: 1'b0};
    vecs[2] = '{rd: 4'b0010, wr: 4'b0000, page: 16'h0BEE, wdata: 64'h0, delay: 19,
                value: 64'h1111, exp_id: 1, exp_rd: 1'b1, exp_data: 64'h0, exp_to: 1'b1};
    vecs[3] = '{rd: 4'b0010, wr: 4'b0000, page: 16'h0C0D, wdata: 64'h0, delay: 16,
                value: 64'hA5A5000000005A5A, exp_id: 1, exp_rd: 1'b1,
                exp_data: 64'hA5A5000000005A5A, exp_to: 1'b0};
    vecs[4] = '{rd: 4'b1000, wr: 4'b1000, page: 16'h0333, wdata: 64'hFFFF, delay: 2,
                value: 64'h77, exp_id: 3, exp_rd: 1'b1, exp_data: 64'h77, exp_to: 1'b0};
    vecs[5] = '{rd: 4'b0000, wr: 4'b0001, page: 16'h0001, wdata: 64'h8000000000000001,
                delay: 1, value: 64'h99, exp_id: 0, exp_rd: 1'b0, exp_data: 64'h0, exp_to: 1'b0};
    vecs[6] = '{rd: 4'b0100, wr: 4'b0000, page: 16'hFFFF, wdata: 64'h0, delay: 15,
                value: 64'h0123, exp_id: 2, exp_rd: 1'b1, exp_data: 64'h0123, exp_to: 1'b0};
    exp_order = '{0, 1, 2, 3, 0, 1};

    do_reset();
    for (int k = 0; k < 7; k++) run_txn(vecs[k]);

    // All four reads held through reset; each drops for one cycle after its ack.
    clear_inputs();
    rst_b = 1'b0;
    req_read = 4'hF;
    step();
    step();
    rst_b = 1'b1;
    inflight = 0; overlaps = 0; done_at = -1; re_id = 0; re_at = -1;
    for (int c = 0; c < 200 && got.size() < 6; c++) begin
      step();
      if (fsm_read | fsm_write) begin
        if (inflight) overlaps++;
        inflight = 1;
        done_at  = c + 2;
      end
      if (rsp_valid) begin
        got.push_back(int'(rsp_id));
        inflight = 0;
        re_id = int'(rsp_id);
        req_read[re_id] = 1'b0;
        re_at = c + 1;
      end
      if (c == re_at) req_read[re_id] = 1'b1;
      fsm_done = (c == done_at);
    end
    fsm_done = 1'b0;
    check("rr grant count", got.size(), 6);
    for (int k = 0; k < got.size(); k++) check("rr grant order", got[k], exp_order[k]);
    check("rr no overlap", overlaps, 0);

    // Reset while requester 2 waits, then done during ISSUE must be ignored.
    do_reset();
    set_operands(2, 16'h0202, 64'h2);
    req_read = 4'b0100;
    step();
    check("t6 grant 2", {fsm_read, fsm_mempage}, {1'b1, 16'h0202});
    step();
    step();
    set_operands(1, 16'h0101, 64'h1);
    req_mempage[32 +: 16] = 16'h0202;
    req_read = 4'b0110;
    rst_b = 1'b0;
    step();
    check_all_zero("reset mid-txn");
    rst_b = 1'b1;
    step();
    check("post-reset start", {fsm_read, fsm_write}, 2'b10);
    check("post-reset page", fsm_mempage, 16'h0101);
    fsm_done = 1'b1;
    fsm_valueRead = 64'h5;
    step();
    check("done in issue ignored", rsp_valid, 1'b0);
    fsm_done = 1'b0;
    step();
    check("still waiting", {rsp_valid, busy}, 2'b01);
    fsm_done = 1'b1;
    fsm_valueRead = 64'h6;
    step();
    check("post-reset ack", req_ack, 4'b0010);
    check("post-reset rsp_data", rsp_data, 64'h6);
    req_read = 4'b0100;
    fsm_done = 1'b0;
    step();
    step();
    check("next grant 2", {fsm_read, fsm_mempage}, {1'b1, 16'h0202});

    do_reset();
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
